// File: rtl/enc_one_hot_seq.sv
// enc_one_hot_seq
// Sequential vector-to-pointer encoder. A captured multi-hot request vector is
// drained as a stream of binary indices, lowest set bit first, one index per
// ptr_valid/ptr_ready handshake. ptr_last marks the final index of a vector.
// All outputs come from registers, so no input reaches an output
// combinationally.
// The parameters are legal only when DEC_BIT_WIDTH <= 2**PTR_BIT_WIDTH.

module enc_one_hot_seq #(
  parameter int PTR_BIT_WIDTH = 3,
  parameter int DEC_BIT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DEC_BIT_WIDTH-1:0] d,
  input  logic                     d_valid,
  output logic                     d_ready,
  output logic [PTR_BIT_WIDTH-1:0] ptr,
  output logic                     ptr_valid,
  input  logic                     ptr_ready,
  output logic                     ptr_last
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                   state_r;
  logic [DEC_BIT_WIDTH-1:0] pending_r;

  logic [DEC_BIT_WIDTH-1:0] rem_s;
  logic [PTR_BIT_WIDTH-1:0] cap_ptr_s;
  logic                     cap_last_s;
  logic [PTR_BIT_WIDTH-1:0] nxt_ptr_s;
  logic                     nxt_last_s;
  logic                     rem_empty_s;
  logic                     d_zero_s;

  // Index of the lowest set bit. The scan runs downward, so the lowest set
  // bit is the last one written. An all-zero vector gives index 0.
  function automatic logic [PTR_BIT_WIDTH-1:0] lowest_idx(
    input logic [DEC_BIT_WIDTH-1:0] v
  );
    logic [PTR_BIT_WIDTH-1:0] idx;
    idx = {PTR_BIT_WIDTH{1'b0}};
    for (int i = DEC_BIT_WIDTH - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = PTR_BIT_WIDTH'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // True when exactly one bit of the vector is set.
  function automatic logic single_bit(input logic [DEC_BIT_WIDTH-1:0] v);
    logic [DEC_BIT_WIDTH-1:0] dec;
    dec = v - DEC_BIT_WIDTH'(1);
    return (v != {DEC_BIT_WIDTH{1'b0}}) && ((v & dec) == {DEC_BIT_WIDTH{1'b0}});
  endfunction

  // Compute the capture values for a new vector and the follow-on values once
  // the current pointer has been consumed.
  always_comb begin
    rem_s = pending_r;
    for (int i = 0; i < DEC_BIT_WIDTH; i++) begin
      if (PTR_BIT_WIDTH'(i) == ptr) begin
        rem_s[i] = 1'b0;
      end else begin
        rem_s[i] = pending_r[i];
      end
    end
    cap_ptr_s   = lowest_idx(d);
    cap_last_s  = single_bit(d);
    nxt_ptr_s   = lowest_idx(rem_s);
    nxt_last_s  = single_bit(rem_s);
    rem_empty_s = (rem_s == {DEC_BIT_WIDTH{1'b0}});
    d_zero_s    = (d == {DEC_BIT_WIDTH{1'b0}});
  end

  // Control FSM with registered handshake and pointer outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      pending_r <= {DEC_BIT_WIDTH{1'b0}};
      d_ready   <= 1'b1;
      ptr       <= {PTR_BIT_WIDTH{1'b0}};
      ptr_valid <= 1'b0;
      ptr_last  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // A zero vector is accepted and dropped; nothing is emitted.
          if (d_valid && !d_zero_s) begin
            state_r   <= BUSY;
            pending_r <= d;
            d_ready   <= 1'b0;
            ptr       <= cap_ptr_s;
            ptr_valid <= 1'b1;
            ptr_last  <= cap_last_s;
          end
        end
        BUSY: begin
          // Outputs hold for as long as the consumer applies backpressure.
          if (ptr_ready) begin
            if (!rem_empty_s) begin
              pending_r <= rem_s;
              ptr       <= nxt_ptr_s;
              ptr_last  <= nxt_last_s;
            end else begin
              state_r   <= IDLE;
              pending_r <= {DEC_BIT_WIDTH{1'b0}};
              d_ready   <= 1'b1;
              ptr       <= {PTR_BIT_WIDTH{1'b0}};
              ptr_valid <= 1'b0;
              ptr_last  <= 1'b0;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          pending_r <= {DEC_BIT_WIDTH{1'b0}};
          d_ready   <= 1'b1;
          ptr       <= {PTR_BIT_WIDTH{1'b0}};
          ptr_valid <= 1'b0;
          ptr_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enc_one_hot_seq.sv
// Directed and random checks for enc_one_hot_seq. Inputs change and outputs are
// sampled on the falling clock edge, half a period away from the active edge.

module tb_enc_one_hot_seq;

  logic       clk;
  logic       rst_n;
  logic [7:0] d;
  logic       d_valid;
  logic       d_ready;
  logic [2:0] ptr;
  logic       ptr_valid;
  logic       ptr_ready;
  logic       ptr_last;

  int checks;
  int failures;

  enc_one_hot_seq #(.PTR_BIT_WIDTH(3), .DEC_BIT_WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d        (d),
    .d_valid  (d_valid),
    .d_ready  (d_ready),
    .ptr      (ptr),
    .ptr_valid(ptr_valid),
    .ptr_ready(ptr_ready),
    .ptr_last (ptr_last)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check all outputs at once against expected values.
  task automatic chk_out(input string tag, input logic exp_valid, input logic [2:0] exp_ptr,
                         input logic exp_last, input logic exp_ready);
    chk({tag, ".ptr_valid"}, {31'd0, ptr_valid}, {31'd0, exp_valid});
    chk({tag, ".ptr"},       {29'd0, ptr},       {29'd0, exp_ptr});
    chk({tag, ".ptr_last"},  {31'd0, ptr_last},  {31'd0, exp_last});
    chk({tag, ".d_ready"},   {31'd0, d_ready},   {31'd0, exp_ready});
  endtask

  function automatic logic [2:0] m_lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      if (v[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  logic [2:0] seq_a6 [4];
  logic       m_busy;
  logic [7:0] m_pend;
  logic [2:0] m_idx;

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    d         = 8'h00;
    d_valid   = 1'b0;
    ptr_ready = 1'b0;
    seq_a6[0] = 3'd1;
    seq_a6[1] = 3'd2;
    seq_a6[2] = 3'd5;
    seq_a6[3] = 3'd7;

    // Reset held for two edges.
    repeat (2) @(negedge clk);
    chk_out("reset", 1'b0, 3'd0, 1'b0, 1'b1);
    rst_n = 1'b1;

    // 8'b1010_0110 drained at full rate.
    d = 8'hA6; d_valid = 1'b1; ptr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      d_valid = 1'b0;
      chk_out($sformatf("a6_%0d", k), 1'b1, seq_a6[k], (k == 3) ? 1'b1 : 1'b0, 1'b0);
    end
    @(negedge clk);
    chk_out("a6_done", 1'b0, 3'd0, 1'b0, 1'b1);

    // 8'b1000_0001 with backpressure.
    d = 8'h81; d_valid = 1'b1; ptr_ready = 1'b0;
    @(negedge clk);
    d_valid = 1'b0;
    chk_out("81_cap", 1'b1, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_out($sformatf("81_hold%0d", k), 1'b1, 3'd0, 1'b0, 1'b0);
    end
    ptr_ready = 1'b1;
    @(negedge clk);
    chk_out("81_p7", 1'b1, 3'd7, 1'b1, 1'b0);
    @(negedge clk);
    chk_out("81_done", 1'b0, 3'd0, 1'b0, 1'b1);

    // Zero vector dropped, then top bit alone.
    d = 8'h00; d_valid = 1'b1;
    @(negedge clk);
    chk_out("zero", 1'b0, 3'd0, 1'b0, 1'b1);
    d = 8'h80;
    @(negedge clk);
    d_valid = 1'b0;
    chk_out("80_p7", 1'b1, 3'd7, 1'b1, 1'b0);
    @(negedge clk);
    chk_out("80_done", 1'b0, 3'd0, 1'b0, 1'b1);

    // 8'hFF interrupted by reset after three accepted pointers.
    d = 8'hFF; d_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      d_valid = 1'b0;
      chk_out($sformatf("ff_%0d", k), 1'b1, 3'(k), 1'b0, 1'b0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk_out("ff_rst", 1'b0, 3'd0, 1'b0, 1'b1);
    rst_n = 1'b1; d = 8'h04; d_valid = 1'b1;
    @(negedge clk);
    d_valid = 1'b0;
    chk_out("04_p2", 1'b1, 3'd2, 1'b1, 1'b0);
    @(negedge clk);
    chk_out("04_done", 1'b0, 3'd0, 1'b0, 1'b1);

    // Random traffic against a cycle model; d_valid also fires during drains.
    m_busy = 1'b0;
    m_pend = 8'h00;
    for (int c = 0; c < 400; c++) begin
      m_idx = m_lowest(m_pend);
      chk_out($sformatf("rnd%0d", c), m_busy, m_busy ? m_idx : 3'd0,
              m_busy && ($countones(m_pend) == 1), !m_busy);
      d         = 8'($urandom_range(0, 255));
      if ((c % 7) == 0) d = 8'h00;
      d_valid   = 1'($urandom_range(0, 1));
      ptr_ready = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
      if (!m_busy) begin
        if (d_valid && (d != 8'h00)) begin
          m_pend = d;
          m_busy = 1'b1;
        end
      end else if (ptr_ready) begin
        m_pend[m_idx] = 1'b0;
        if (m_pend == 8'h00) m_busy = 1'b0;
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
